sync_arb_ctrl: RTL and testbench

SYNC_ARB_CTRL -- requirements
Module: sync_arb_ctrl

---
 rtl/sync_arb_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sync_arb_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_arb_ctrl.sv
// sync_arb_ctrl
//    Round-robin arbiter that shares one edge-sync channel between N_REQ
//    requesters. A winner gets sync_vld high for HOLD_CYC cycles followed
//    by GAP_CYC low cycles, with a one-cycle ack at the end of the gap.
//    When the channel has been idle for IDLE_CYC cycles, its clock gate
//    (edge_en) is dropped, and it is re-enabled WAKE_CYC cycles before
//    the next launch.
//
//    Build option: SYNC_ARB_IDLE_GATE_EN
//       defined   : edge_en gating with OFF/WAKE/LINGER timeout
//       undefined : reset into LINGER, no timeout, edge_en tied high
//
// Ports
//    clk_a     in   clock, rising edge
//    rst_n_a   in   asynchronous active-low reset
//    req       in   [N_REQ] level requests, held until ack
//    ack       out  [N_REQ] one-cycle completion pulse
//    gnt_id    out  index of the current channel owner
//    sync_vld  out  level into the edge-sync source flop
//    edge_en   out  clock-gate enable for the edge-sync channel
//    busy      out  high in WAKE, ARB, HOLD, GAP
//
// state  | meaning
// OFF    | channel clock gated, waiting for any request
// WAKE   | gate open, waiting for the gated clock to settle
// ARB    | one-cycle round-robin pick
// HOLD   | sync_vld high for the granted requester
// GAP    | sync_vld low, ack on the final cycle
// LINGER | gate still open, idle timeout running
module sync_arb_ctrl #(
   parameter int N_REQ    = 4,
   parameter int WAKE_CYC = 2,
   parameter int HOLD_CYC = 4,
   parameter int GAP_CYC  = 4,
   parameter int IDLE_CYC = 8
) (
   input  logic                       clk_a,
   input  logic                       rst_n_a,
   input  logic [N_REQ-1:0]           req,
   output logic [N_REQ-1:0]           ack,
   output logic [$clog2(N_REQ)-1:0]   gnt_id,
   output logic                       sync_vld,
   output logic                       edge_en,
   output logic                       busy
);

   localparam int ID_W = $clog2(N_REQ);

   // A zero parameter behaves as one cycle.
   localparam logic [7:0] WAKE_LD = (WAKE_CYC < 1) ? 8'd1 : 8'(WAKE_CYC);
   localparam logic [7:0] HOLD_LD = (HOLD_CYC < 1) ? 8'd1 : 8'(HOLD_CYC);
   localparam logic [7:0] GAP_LD  = (GAP_CYC  < 1) ? 8'd1 : 8'(GAP_CYC);
   // The ARB cycle that finds nobody counts as the first idle cycle.
   localparam logic [7:0] IDLE_LD = (IDLE_CYC <= 1) ? 8'd0 : 8'(IDLE_CYC - 1);

   typedef enum logic [2:0] {OFF, WAKE, ARB, HOLD, GAP, LINGER} state_t;

`ifdef SYNC_ARB_IDLE_GATE_EN
   localparam state_t RST_ST = OFF;
   localparam logic   RST_EE = 1'b0;
`else
   localparam state_t RST_ST = LINGER;
   localparam logic   RST_EE = 1'b1;
`endif

   state_t           state;
   logic [7:0]       cnt;
   logic [ID_W-1:0]  ptr;
   logic [N_REQ-1:0] mask;

   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] gnt_oh;
   logic             win_vld;
   logic [ID_W-1:0]  win_id;
   logic [ID_W:0]    pos;
   logic [ID_W-1:0]  ptr_inc;

   assign gnt_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_id;
   assign ptr_inc = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + ID_W'(1);

   // Descending scan so the lowest offset from ptr is the last to write.
   always_comb begin
      elig    = req & ~mask;
      win_vld = 1'b0;
      win_id  = '0;
      pos     = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         pos = {1'b0, ptr} + (ID_W+1)'(i);
         if (pos >= (ID_W+1)'(N_REQ))
            pos = pos - (ID_W+1)'(N_REQ);
         if (elig[pos[ID_W-1:0]]) begin
            win_vld = 1'b1;
            win_id  = pos[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk_a or negedge rst_n_a) begin
      if (!rst_n_a) begin
         state    <= RST_ST;
         edge_en  <= RST_EE;
         cnt      <= '0;
         ptr      <= '0;
         mask     <= '0;
         gnt_id   <= '0;
         ack      <= '0;
         sync_vld <= 1'b0;
         busy     <= 1'b0;
      end else begin
         ack <= '0;
         case (state)
            OFF: begin
               if (|req) begin
                  state   <= WAKE;
                  cnt     <= WAKE_LD;
                  edge_en <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            WAKE: begin
               if (cnt <= 8'd1) state <= ARB;
               else             cnt   <= cnt - 8'd1;
            end
            ARB: begin
               mask <= '0;
               if (win_vld) begin
                  state    <= HOLD;
                  gnt_id   <= win_id;
                  cnt      <= HOLD_LD;
                  sync_vld <= 1'b1;
               end else begin
                  state <= LINGER;
                  cnt   <= IDLE_LD;
                  busy  <= 1'b0;
               end
            end
            HOLD: begin
               if (cnt <= 8'd1) begin
                  state    <= GAP;
                  cnt      <= GAP_LD;
                  sync_vld <= 1'b0;
                  if (GAP_LD == 8'd1) ack <= gnt_oh;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            GAP: begin
               if (cnt <= 8'd1) begin
                  state <= ARB;
                  ptr   <= ptr_inc;
                  mask  <= gnt_oh;
               end else begin
                  cnt <= cnt - 8'd1;
                  // next cycle is the last gap cycle
                  if (cnt == 8'd2) ack <= gnt_oh;
               end
            end
            LINGER: begin
               if (|req) begin
                  state <= ARB;
                  busy  <= 1'b1;
               end
`ifdef SYNC_ARB_IDLE_GATE_EN
               else if (cnt <= 8'd1) begin
                  state   <= OFF;
                  edge_en <= 1'b0;
               end else begin
                  cnt <= cnt - 8'd1;
               end
`endif
            end
            default: state <= RST_ST;
         endcase
      end
   end

endmodule

// File: tb/tb_sync_arb_ctrl.sv
module tb_sync_arb_ctrl;

   localparam int N    = 4;
   localparam int IDW  = 2;
   localparam int WAKE = 2;
   localparam int HOLD = 4;
   localparam int GAP  = 4;
   localparam int IDLE = 8;

`ifdef SYNC_ARB_IDLE_GATE_EN
   localparam bit         GATE       = 1'b1;
   localparam logic [3:0] S1_REQ     = 4'b0100;
   localparam int         S1_GNT     = 2;
   localparam int         S1_EE0     = 0;
   localparam int         S1_SV      = 4;
   localparam int         S1_SV_END  = 7;
   localparam int         S1_ACK     = 11;
   localparam int         S1_DROP    = 20;
   localparam int         RST_EE     = 0;
   localparam int         RESTART_SV = 4;
`else
   localparam bit         GATE       = 1'b0;
   localparam logic [3:0] S1_REQ     = 4'b0001;
   localparam int         S1_GNT     = 0;
   localparam int         S1_EE0     = 1;
   localparam int         S1_SV      = 2;
   localparam int         S1_SV_END  = 5;
   localparam int         S1_ACK     = 9;
   localparam int         S1_DROP    = -1;
   localparam int         RST_EE     = 1;
   localparam int         RESTART_SV = 2;
`endif

   logic           clk_a   = 1'b0;
   logic           rst_n_a = 1'b1;
   logic [N-1:0]   req     = '0;
   logic [N-1:0]   ack;
   logic [IDW-1:0] gnt_id;
   logic           sync_vld;
   logic           edge_en;
   logic           busy;

   int n_cmp = 0;
   int n_bad = 0;

   sync_arb_ctrl #(
      .N_REQ(N), .WAKE_CYC(WAKE), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .IDLE_CYC(IDLE)
   ) dut (
      .clk_a(clk_a), .rst_n_a(rst_n_a), .req(req), .ack(ack),
      .gnt_id(gnt_id), .sync_vld(sync_vld), .edge_en(edge_en), .busy(busy)
   );

   always #5 clk_a = ~clk_a;

   // ---------------- behavioural model: timeline of expected frames ----
   typedef struct packed {
      logic           arb;
      logic           bz;
      logic           ee;
      logic           sv;
      logic [N-1:0]   ak;
      logic [IDW-1:0] g;
   } frame_t;

   frame_t       plan[$];
   frame_t       cur;
   int           m_mode;   // 0: gated off, 1: lingering
   int           m_ptr;
   int           m_left;
   int           m_gnt;
   logic [N-1:0] m_mask;

   function automatic frame_t mk(bit arb, bit bz, bit ee, bit sv, logic [N-1:0] ak, int g);
      frame_t f;
      f.arb = arb; f.bz = bz; f.ee = ee; f.sv = sv; f.ak = ak; f.g = IDW'(g);
      return f;
   endfunction

   always @(posedge clk_a or negedge rst_n_a) begin : model
      logic [N-1:0] r, elig, oh;
      int win, c;
      if (!rst_n_a) begin
         plan.delete();
         m_ptr  = 0;
         m_mask = '0;
         m_gnt  = 0;
         m_left = 0;
         m_mode = GATE ? 0 : 1;
         cur    = mk(0, 0, !GATE, 0, '0, 0);
      end else begin
         r = req;
         if (cur.arb) begin
            elig   = r & ~m_mask;
            m_mask = '0;
            win    = -1;
            for (int k = 0; k < N; k++) begin
               c = (m_ptr + k) % N;
               if (win < 0 && elig[IDW'(c)]) win = c;
            end
            if (win >= 0) begin
               m_gnt  = win;
               m_ptr  = (win + 1) % N;
               oh     = N'(1) << win;
               m_mask = oh;
               for (int h = 0; h < HOLD; h++) plan.push_back(mk(0, 1, 1, 1, '0, win));
               for (int gp = 0; gp < GAP; gp++)
                  plan.push_back(mk(0, 1, 1, 0, (gp == GAP-1) ? oh : {N{1'b0}}, win));
               plan.push_back(mk(1, 1, 1, 0, '0, win));
            end else begin
               m_mode = 1;
               m_left = (IDLE > 1) ? IDLE - 1 : 1;
            end
         end else if (plan.size() == 0) begin
            if (m_mode == 0) begin
               if (|r) begin
                  for (int w = 0; w < WAKE; w++) plan.push_back(mk(0, 1, 1, 0, '0, m_gnt));
                  plan.push_back(mk(1, 1, 1, 0, '0, m_gnt));
               end
            end else if (|r) begin
               plan.push_back(mk(1, 1, 1, 0, '0, m_gnt));
            end else if (GATE) begin
               m_left--;
               if (m_left == 0) m_mode = 0;
            end
         end
         if (plan.size() > 0) cur = plan.pop_front();
         else                 cur = mk(0, 0, m_mode != 0, 0, '0, m_gnt);
      end
   end

   always @(negedge clk_a) begin
      n_cmp++;
      if ({sync_vld, ack, gnt_id, edge_en, busy} !== {cur.sv, cur.ak, cur.g, cur.ee, cur.bz}) begin
         n_bad++;
         $display("FAIL cycle_model t=%0t sv/ack/gnt/ee/busy got %b/%b/%0d/%b/%b expected %b/%b/%0d/%b/%b",
                  $time, sync_vld, ack, gnt_id, edge_en, busy,
                  cur.sv, cur.ak, cur.g, cur.ee, cur.bz);
      end
   end

   // ---------------- helpers --------------------------------------------
   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_a);
      #1 rst_n_a = 1'b0;
      req = '0;
      repeat (2) @(negedge clk_a);
      #2 rst_n_a = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random stimulus -------------------------
   initial begin : stim
      int sv_first, sv_last, ack_cyc, ack_val, ee_drop, g_hold, ee0, ee1;
      int gr[4], ac[4];
      int ng, na, run, n, ak, nsv, bz2, b5, s6, g6, eez;
      logic psv;
      logic [N-1:0] stale, nreq;
      int lim;

      #1 rst_n_a = 1'b0;
      repeat (2) @(negedge clk_a);
      chk("reset_sv", sync_vld, 0);
      chk("reset_ack", ack, 0);
      chk("reset_gnt", gnt_id, 0);
      chk("reset_busy", busy, 0);
      chk("reset_ee", edge_en, RST_EE);
      #2 rst_n_a = 1'b1;
      repeat (2) @(negedge clk_a);

      // single request timeline
      sv_first = -1; sv_last = -1; ack_cyc = -1; ack_val = -1;
      ee_drop = -1; g_hold = -1; ee0 = -1; ee1 = -1;
      for (int k = 0; k < 26; k++) begin
         @(negedge clk_a);
         if (k == 0) ee0 = edge_en;
         if (k == 1) ee1 = edge_en;
         if (sync_vld) begin
            if (sv_first < 0) begin sv_first = k; g_hold = gnt_id; end
            sv_last = k;
         end
         if (|ack) begin
            if (ack_cyc < 0) begin ack_cyc = k; ack_val = ack; end
            req = '0;
         end
         if (k > 0 && !edge_en && ee_drop < 0) ee_drop = k;
         if (k == 0) req = S1_REQ;
      end
      chk("s1_ee_c0", ee0, S1_EE0);
      chk("s1_ee_c1", ee1, 1);
      chk("s1_sv_first", sv_first, S1_SV);
      chk("s1_sv_last", sv_last, S1_SV_END);
      chk("s1_gnt", g_hold, S1_GNT);
      chk("s1_ack_cyc", ack_cyc, S1_ACK);
      chk("s1_ack_val", ack_val, int'(S1_REQ));
      chk("s1_ee_drop", ee_drop, S1_DROP);

      // contention 1011 from pointer 0
      do_reset();
      foreach (gr[i]) begin gr[i] = -1; ac[i] = -1; end
      ng = 0; na = 0; run = 0; psv = 1'b0;
      @(negedge clk_a);
      req = 4'b1011;
      for (int k = 1; k < 80 && na < 4; k++) begin
         @(negedge clk_a);
         if (sync_vld && !psv && ng < 4) begin gr[ng] = gnt_id; ng++; end
         if (sync_vld && ng == 1) run++;
         if (|ack && na < 4) begin ac[na] = k; na++; end
         psv = sync_vld;
      end
      req = '0;
      chk("s2_grant0", gr[0], 0);
      chk("s2_grant1", gr[1], 1);
      chk("s2_grant2", gr[2], 3);
      chk("s2_grant3", gr[3], 0);
      chk("s2_hold_len", run, HOLD);
      chk("s2_ack_space01", ac[1] - ac[0], 9);
      chk("s2_ack_space12", ac[2] - ac[1], 9);
      chk("s2_ack_space23", ac[3] - ac[2], 9);

      // reset during the second HOLD cycle
      do_reset();
      @(negedge clk_a);
      req = 4'b0100;
      n = 0;
      for (int k = 0; k < 30 && n < 2; k++) begin
         @(negedge clk_a);
         if (sync_vld) n++;
      end
      chk("s3_reach_hold2", n, 2);
      #1 rst_n_a = 1'b0;
      #1;
      chk("s3_rst_sv", sync_vld, 0);
      chk("s3_rst_ack", ack, 0);
      chk("s3_rst_ee", edge_en, RST_EE);
      chk("s3_rst_busy", busy, 0);
      chk("s3_rst_gnt", gnt_id, 0);
      repeat (2) @(negedge clk_a);
      #2 rst_n_a = 1'b1;
      sv_first = -1;
      for (int k = 1; k < 15; k++) begin
         @(negedge clk_a);
         if (sync_vld && sv_first < 0) sv_first = k;
      end
      chk("s3_restart_sv", sv_first, RESTART_SV);
      n = 0;
      for (int k = 0; k < 20 && n == 0; k++) begin
         @(negedge clk_a);
         if (|ack) begin n = 1; req = '0; end
      end
      chk("s3_ack_after_restart", n, 1);

      // stale request one cycle past ack
      do_reset();
      @(negedge clk_a);
      req = 4'b0100;
      ak = -1; nsv = 0; bz2 = -1;
      for (int k = 1; k < 40; k++) begin
         @(negedge clk_a);
         if (sync_vld) nsv++;
         if (|ack && ak < 0) ak = k;
         if (ak >= 0 && k == ak + 1) req = '0;
         if (ak >= 0 && k == ak + 2) bz2 = busy;
      end
      chk("s4_ack_cyc", ak, S1_ACK);
      chk("s4_single_grant", nsv, HOLD);
      chk("s4_linger_busy", bz2, 0);

      // re-request three cycles into LINGER
      do_reset();
      @(negedge clk_a);
      req = 4'b0001;
      ak = -1; b5 = -1; s6 = -1; g6 = -1; eez = 0;
      for (int k = 1; k < 40; k++) begin
         @(negedge clk_a);
         if (|ack) begin
            if (ak < 0) ak = k;
            req = '0;
         end
         if (ak >= 0) begin
            if (k == ak + 4) req = 4'b0010;
            if (k == ak + 5) b5 = busy;
            if (k == ak + 6) begin s6 = sync_vld; g6 = gnt_id; end
            if (k <= ak + 10 && !edge_en) eez++;
         end
      end
      chk("s5_arb_busy", b5, 1);
      chk("s5_hold_sv", s6, 1);
      chk("s5_hold_gnt", g6, 1);
      chk("s5_ee_low_cycles", eez, 0);

      // randomized traffic against the model
      do_reset();
      stale = '0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk_a);
         if (t == 1500) #1 rst_n_a = 1'b0;
         if (t == 1503) #2 rst_n_a = 1'b1;
         lim  = (t >= 2000 && t < 2600) ? 60 : 5;
         nreq = req;
         for (int i = 0; i < N; i++) begin
            if (stale[i]) begin
               nreq[i]  = 1'b0;
               stale[i] = 1'b0;
            end else if (req[i] && ack[i]) begin
               if ($urandom_range(3) == 0) stale[i] = 1'b1;
               else                        nreq[i]  = 1'b0;
            end else if (req[i]) begin
               if ($urandom_range(63) == 0) nreq[i] = 1'b0;
            end else if ($urandom_range(lim) == 0) begin
               nreq[i] = 1'b1;
            end
         end
         req = nreq;
      end
      req = '0;
      repeat (30) @(negedge clk_a);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
